// File: rtl/pc_sequencer_pkg.sv
// Shared processor package: run-control state encoding and default widths
// for the PC sequencer.
package pc_sequencer_pkg;

  localparam int PC_W_DEF  = 3;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_pc_next_logic.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_logic
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_sig_jump,
  input  logic            i_sig_branch,
  input  logic            i_zero_flag,
  input  logic [PC_W-1:0] i_br_off,
  input  logic [PC_W-1:0] i_jump_target,
  output logic [PC_W-1:0] o_next_pc
);

  logic [PC_W-1:0] w_pc_inc;

  // br_off is already PC_W wide, so adding it modulo 2^PC_W is the sign-extended add.
  assign w_pc_inc = i_pc + PC_W'(1);

  always_comb begin
    o_next_pc = w_pc_inc;
    if (i_sig_jump) begin
      o_next_pc = i_jump_target;
    end else if (i_sig_branch && i_zero_flag) begin
      o_next_pc = w_pc_inc + i_br_off;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Run-control / program-counter sequencer: HALTED/RUN/STEP FSM, PC register,
// commit enable and retired-instruction counter. Optional breakpoint: PC_SEQ_BREAKPOINT_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             load_en,
  input  logic [PC_W-1:0]  load_pc,
  input  logic             sig_jump,
  input  logic             sig_branch,
  input  logic             zero_flag,
  input  logic [PC_W-1:0]  br_off,
  input  logic [PC_W-1:0]  jump_target,
  output logic [PC_W-1:0]  pc,
  output logic             exec_en,
  output logic             halted,
  output logic [CNT_W-1:0] retired
`ifdef PC_SEQ_BREAKPOINT_EN
  ,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             bp_hit
`endif
);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_next;
  logic [PC_W-1:0]  w_seq_pc;
  logic [CNT_W-1:0] r_retired;
  logic             w_exec_en;

  pc_next_logic #(
    .PC_W (PC_W)
  ) u_pc_next_logic (
    .i_pc          (r_pc),
    .i_sig_jump    (sig_jump),
    .i_sig_branch  (sig_branch),
    .i_zero_flag   (zero_flag),
    .i_br_off      (br_off),
    .i_jump_target (jump_target),
    .o_next_pc     (w_seq_pc)
  );

`ifdef PC_SEQ_BREAKPOINT_EN
  logic r_resume;
  logic w_bp_stop;

  // The first RUN cycle after HALTED skips the breakpoint so execution can resume from it.
  assign w_bp_stop = (r_state == ST_RUN) && bp_en && (r_pc == bp_addr) && !r_resume;
  assign bp_hit    = w_bp_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resume <= 1'b0;
    end else begin
      r_resume <= (r_state == ST_HALTED) && (w_state_next == ST_RUN);
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_exec_en    = 1'b0;
    case (r_state)
      ST_HALTED: begin
        if (load_en) begin
          w_pc_next = load_pc;
        end else if (halt_req) begin
          w_state_next = ST_HALTED;
        end else if (step_req) begin
          w_state_next = ST_STEP;
        end else if (run_req) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_exec_en = 1'b1;
        if (load_en) begin
          w_pc_next    = load_pc;
          w_state_next = ST_HALTED;
        end else if (halt_req) begin
          w_pc_next    = w_seq_pc;
          w_state_next = ST_HALTED;
        end else begin
          w_pc_next = w_seq_pc;
        end
`ifdef PC_SEQ_BREAKPOINT_EN
        // Breakpoint suppresses the commit and freezes pc; a manual load still applies.
        if (w_bp_stop) begin
          w_exec_en    = 1'b0;
          w_state_next = ST_HALTED;
          w_pc_next    = load_en ? load_pc : r_pc;
        end
`endif
      end
      ST_STEP: begin
        w_exec_en    = 1'b1;
        w_pc_next    = load_en ? load_pc : w_seq_pc;
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_HALTED;
      r_pc      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_exec_en && (r_retired != {CNT_W{1'b1}})) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign pc      = r_pc;
  assign exec_en = w_exec_en;
  assign halted  = (r_state == ST_HALTED);
  assign retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a scoreboard of expected commits
// (pc, retired-before) is checked whenever exec_en is seen high.
module tb_pc_sequencer;

  localparam int PC_W  = 3;
  localparam int CNT_W = 16;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] ret;
  } commit_t;

  logic             clk;
  logic             rst;
  logic             run_req, step_req, halt_req, load_en;
  logic [PC_W-1:0]  load_pc, br_off, jump_target;
  logic             sig_jump, sig_branch, zero_flag;
  logic [PC_W-1:0]  pc;
  logic             exec_en, halted;
  logic [CNT_W-1:0] retired;
`ifdef PC_SEQ_BREAKPOINT_EN
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_hit;
`endif

  int               n_tests;
  int               n_fail;
  commit_t          exp_q[$];
  logic [CNT_W-1:0] exp_ret;

  pc_sequencer #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_req     (run_req),
    .step_req    (step_req),
    .halt_req    (halt_req),
    .load_en     (load_en),
    .load_pc     (load_pc),
    .sig_jump    (sig_jump),
    .sig_branch  (sig_branch),
    .zero_flag   (zero_flag),
    .br_off      (br_off),
    .jump_target (jump_target),
    .pc          (pc),
    .exec_en     (exec_en),
    .halted      (halted),
    .retired     (retired)
`ifdef PC_SEQ_BREAKPOINT_EN
    ,
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .bp_hit      (bp_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every committed instruction must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && exec_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: got pc=%0d, required no commit", pc);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        if (pc !== e.pc || retired !== e.ret) begin
          n_fail++;
          $display("FAIL commit: got pc=%0d retired=%0d, required pc=%0d retired=%0d",
                   pc, retired, e.pc, e.ret);
        end else begin
          $display("[TB] commit pc=%0d retired=%0d", pc, retired);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_commit(input logic [PC_W-1:0] p);
    commit_t c;
    c.pc  = p;
    c.ret = exp_ret;
    exp_q.push_back(c);
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_commits: got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_halted_at(input string name, input logic [PC_W-1:0] p);
    n_tests++;
    if (pc !== p || halted !== 1'b1 || exec_en !== 1'b0 || retired !== exp_ret) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d halted=%0b exec_en=%0b retired=%0d, required pc=%0d halted=1 exec_en=0 retired=%0d",
               name, pc, halted, exec_en, retired, p, exp_ret);
    end else begin
      $display("[TB] %s pc=%0d halted retired=%0d", name, pc, retired);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    check_halted_at("reset", 3'd0);
    rst = 1'b0;
    tick();
    check_halted_at("reset_release", 3'd0);
  endtask

  task automatic test_run_wrap();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_commit(PC_W'(i % 8));
      if (i == 8) halt_req = 1'b1;
      tick();
    end
    halt_req = 1'b0;
    check_halted_at("run_wrap", 3'd1);
    check_drained("run_wrap");
  endtask

  task automatic test_step();
    load_en = 1'b1;
    load_pc = 3'd2;
    tick();
    load_en = 1'b0;
    check_halted_at("step_load", 3'd2);
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      push_commit(PC_W'(2 + i));
      tick();
      tick();
    end
    check_halted_at("step_x3", 3'd5);
    check_drained("step");
  endtask

  task automatic test_branch();
    load_en = 1'b1;
    load_pc = 3'd3;
    tick();
    load_en = 1'b0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    sig_branch = 1'b1;
    zero_flag  = 1'b1;
    br_off     = 3'b110;
    push_commit(3'd3);
    tick();
    n_tests++;
    if (pc !== 3'd2 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_taken: got pc=%0d halted=%0b, required pc=2 halted=0", pc, halted);
    end
    sig_branch = 1'b0;
    push_commit(3'd2);
    tick();
    sig_branch = 1'b1;
    zero_flag  = 1'b0;
    halt_req   = 1'b1;
    push_commit(3'd3);
    tick();
    sig_branch = 1'b0;
    halt_req   = 1'b0;
    check_halted_at("branch_not_taken", 3'd4);
    check_drained("branch");
  endtask

  task automatic test_jump_halt();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    sig_jump    = 1'b1;
    jump_target = 3'd6;
    sig_branch  = 1'b1;
    zero_flag   = 1'b1;
    br_off      = 3'd1;
    halt_req    = 1'b1;
    push_commit(3'd4);
    tick();
    sig_jump   = 1'b0;
    sig_branch = 1'b0;
    halt_req   = 1'b0;
    check_halted_at("jump_halt", 3'd6);
    check_drained("jump_halt");
  endtask

  task automatic test_priority();
    halt_req = 1'b1;
    run_req  = 1'b1;
    tick();
    halt_req = 1'b0;
    run_req  = 1'b0;
    check_halted_at("halt_beats_run", 3'd6);
    load_en  = 1'b1;
    load_pc  = 3'd1;
    step_req = 1'b1;
    tick();
    load_en  = 1'b0;
    step_req = 1'b0;
    tick();
    check_halted_at("load_beats_step", 3'd1);
    // run_req held: halt takes one cycle, then RUN re-enters.
    run_req = 1'b1;
    tick();
    halt_req = 1'b1;
    push_commit(3'd1);
    tick();
    halt_req = 1'b0;
    check_halted_at("held_run_halt", 3'd2);
    tick();
    run_req = 1'b0;
    halt_req = 1'b1;
    push_commit(3'd2);
    n_tests++;
    if (halted !== 1'b0 || exec_en !== 1'b1) begin
      n_fail++;
      $display("FAIL held_run_reenter: got halted=%0b exec_en=%0b, required halted=0 exec_en=1", halted, exec_en);
    end
    tick();
    halt_req = 1'b0;
    check_halted_at("held_run_stop", 3'd3);
    check_drained("priority");
  endtask

  task automatic test_load_run_and_rst();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    push_commit(3'd3);
    tick();
    load_en = 1'b1;
    load_pc = 3'd5;
    push_commit(3'd4);
    tick();
    load_en = 1'b0;
    check_halted_at("load_in_run", 3'd5);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    push_commit(3'd5);
    tick();
    // Mid-cycle asynchronous reset abandons the commit at pc=6.
    #2;
    rst = 1'b1;
    #1;
    exp_ret = '0;
    check_halted_at("rst_mid_run", 3'd0);
    tick();
    rst = 1'b0;
    tick();
    check_halted_at("rst_release", 3'd0);
    check_drained("load_rst");
  endtask

`ifdef PC_SEQ_BREAKPOINT_EN
  task automatic test_breakpoint();
    bp_en   = 1'b1;
    bp_addr = 3'd4;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_commit(PC_W'(i));
      tick();
    end
    n_tests++;
    if (bp_hit !== 1'b1 || exec_en !== 1'b0 || pc !== 3'd4) begin
      n_fail++;
      $display("FAIL bp_hit: got bp_hit=%0b exec_en=%0b pc=%0d, required 1 0 4", bp_hit, exec_en, pc);
    end
    tick();
    check_halted_at("bp_halt", 3'd4);
    n_tests++;
    if (bp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pulse: got bp_hit=%0b, required 0", bp_hit);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    push_commit(3'd4);
    tick();
    halt_req = 1'b1;
    push_commit(3'd5);
    tick();
    halt_req = 1'b0;
    bp_en = 1'b0;
    check_halted_at("bp_resume", 3'd6);
    check_drained("breakpoint");
  endtask
`endif

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    exp_ret     = '0;
    rst         = 1'b1;
    run_req     = 1'b0;
    step_req    = 1'b0;
    halt_req    = 1'b0;
    load_en     = 1'b0;
    load_pc     = '0;
    sig_jump    = 1'b0;
    sig_branch  = 1'b0;
    zero_flag   = 1'b0;
    br_off      = '0;
    jump_target = '0;
`ifdef PC_SEQ_BREAKPOINT_EN
    bp_en       = 1'b0;
    bp_addr     = '0;
`endif
    test_reset();
    test_run_wrap();
    test_step();
    test_branch();
    test_jump_halt();
    test_priority();
    test_load_run_and_rst();
`ifdef PC_SEQ_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
